// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable Moore sequence detector.
package seq_det_pkg;

   // Legal range of the pattern length parameter
   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

   // Overlapping detection is the power-up behaviour
   localparam logic OVERLAP_RST = 1'b1;

   // Width needed to hold a matched-prefix length in 0..pat_w
   function automatic int state_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_det_prefix_len.sv
// Combinational longest-prefix calculator: given the recent accepted bits
// (newest in bit 0) returns the longest pattern prefix that ends on them.
module seq_det_prefix_len
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4,
   localparam int SW = state_w(PAT_W)
)(
   input  logic [PAT_W:0]   seq,
   input  logic [PAT_W-1:0] pattern_q,
   input  logic [PAT_W-1:0] mask,
   input  logic [SW-1:0]    fill_eff,
   output logic [SW-1:0]    next
);

   logic [PAT_W-1:0] pat_sh;
   logic [PAT_W-1:0] care;

   // Try every prefix length upward; the last one that fits the history wins
   always_comb begin
      next   = '0;
      pat_sh = '0;
      care   = '0;
      for (int k = 1; k <= PAT_W; k++) begin
         pat_sh = pattern_q >> (PAT_W - k);
         care   = (mask >> (PAT_W - k)) & ({PAT_W{1'b1}} >> (PAT_W - k));
         if ((k <= int'(fill_eff) + 1) &&
             (((({1'b0, pat_sh}) ^ seq) & {1'b0, care}) == '0))
            next = SW'(k);
      end
   end

endmodule

// File: rtl/seq_det_moore_prog.sv
// Parametrised Moore serial sequence detector with a runtime-programmable
// pattern, overlap control and a saturating match counter.
// Optional feature macro: SEQ_DET_MASK_EN adds pattern_mask (don't-care bits).
module seq_det_moore_prog
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       x_valid,
   input  logic                       x,
   input  logic                       cfg_load,
   input  logic [PAT_W-1:0]           pattern,
   input  logic                       overlap_en,
   input  logic                       cnt_clr,
   output logic                       z,
   output logic [$clog2(PAT_W+1)-1:0] match_len,
   output logic [CNT_W-1:0]           match_cnt
`ifdef SEQ_DET_MASK_EN
   ,
   input  logic [PAT_W-1:0]           pattern_mask
`endif
);

   localparam int SW = state_w(PAT_W);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_det_moore_prog: PAT_W out of range");
   end

   logic [SW-1:0]    state;
   logic [PAT_W-1:0] hist;
   logic [SW-1:0]    fill;
   logic [PAT_W-1:0] pattern_q;
   logic             overlap_q;
   logic [PAT_W-1:0] mask_q;
   logic [SW-1:0]    fill_eff;
   logic [SW-1:0]    fill_next;
   logic [SW-1:0]    next_len;
   logic             at_match;
   logic             cnt_inc;

`ifndef SEQ_DET_MASK_EN
   assign mask_q = '1;
`endif

   // After a non-overlapping match the history is forgotten so the next
   // match has to start from the bit after the completing one
   assign at_match  = (state == SW'(PAT_W));
   assign fill_eff  = (at_match && !overlap_q) ? '0 : fill;
   assign fill_next = (fill_eff == SW'(PAT_W)) ? fill_eff : fill_eff + SW'(1);
   assign cnt_inc   = !cfg_load && x_valid && (next_len == SW'(PAT_W));

   seq_det_prefix_len #(
      .PAT_W(PAT_W)
   ) u_prefix (
      .seq      ({hist, x}),
      .pattern_q(pattern_q),
      .mask     (mask_q),
      .fill_eff (fill_eff),
      .next     (next_len)
   );

   // State, history and configuration: reset beats cfg_load beats an accepted bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= '0;
         hist      <= '0;
         fill      <= '0;
         pattern_q <= '0;
         overlap_q <= OVERLAP_RST;
`ifdef SEQ_DET_MASK_EN
         mask_q    <= '1;
`endif
      end else if (cfg_load) begin
         state     <= '0;
         hist      <= '0;
         fill      <= '0;
         pattern_q <= pattern;
         overlap_q <= overlap_en;
`ifdef SEQ_DET_MASK_EN
         mask_q    <= pattern_mask;
`endif
      end else if (x_valid) begin
         state <= next_len;
         hist  <= {hist[PAT_W-2:0], x};
         fill  <= fill_next;
      end
   end

   // Saturating match counter; a clear always wins over a coincident match
   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (cnt_inc && (match_cnt != '1)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

   assign z         = at_match;
   assign match_len = state;

endmodule

// File: tb/tb_seq_det_moore_prog.sv
// Self-checking bench for seq_det_moore_prog: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_seq_det_moore_prog;

   localparam int PW   = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;
`ifdef SEQ_DET_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          x_valid = 1'b0;
   logic          x = 1'b0;
   logic          cfg_load = 1'b0;
   logic [PW-1:0] pattern = '0;
   logic          overlap_en = 1'b1;
   logic          cnt_clr = 1'b0;
   logic [PW-1:0] pmask = '1;
   logic          z;
   logic [2:0]    match_len;
   logic [CW-1:0] match_cnt;

   int errors = 0;
   int checks = 0;

   seq_det_moore_prog #(
      .PAT_W(PW),
      .CNT_W(CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .x_valid     (x_valid),
      .x           (x),
      .cfg_load    (cfg_load),
      .pattern     (pattern),
      .overlap_en  (overlap_en),
      .cnt_clr     (cnt_clr),
      .z           (z),
      .match_len   (match_len),
      .match_cnt   (match_cnt)
`ifdef SEQ_DET_MASK_EN
      ,
      .pattern_mask(pmask)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference model: bits since the last restart, oldest first
   bit          m_q[$];
   int          m_state;
   int          m_cnt;
   bit [PW-1:0] m_pat;
   bit [PW-1:0] m_mask;
   bit          m_ovl;

   function automatic int model_longest();
      int best = 0;
      int n = m_q.size();
      for (int k = 1; k <= n; k++) begin
         bit ok = 1'b1;
         for (int i = 0; i < k; i++)
            if (m_mask[PW-1-i] && (m_q[n-k+i] != m_pat[PW-1-i])) ok = 1'b0;
         if (ok) best = k;
      end
      return best;
   endfunction

   function automatic void model_step(input bit r, input bit c, input bit clr,
                                      input bit xv, input bit xb);
      bit inc = 1'b0;
      if (r) begin
         m_q.delete();
         m_state = 0;
         m_cnt   = 0;
         m_pat   = '0;
         m_mask  = '1;
         m_ovl   = 1'b1;
         return;
      end
      if (c) begin
         m_pat  = pattern;
         m_ovl  = overlap_en;
         m_mask = MASK_EN ? pmask : '1;
         m_q.delete();
         m_state = 0;
      end else if (xv) begin
         if (m_state == PW && !m_ovl) m_q.delete();
         m_q.push_back(xb);
         if (m_q.size() > PW) void'(m_q.pop_front());
         m_state = model_longest();
         inc = (m_state == PW);
      end
      if (clr) m_cnt = 0;
      else if (inc && m_cnt < CMAX) m_cnt++;
   endfunction

   // One clock of stimulus; outputs are stable for checking on return
   task automatic step(input bit r, input bit c, input bit clr, input bit xv, input bit xb);
      rst = r; cfg_load = c; cnt_clr = clr; x_valid = xv; x = xb;
      model_step(r, c, clr, xv, xb);
      @(posedge clk);
      #1;
      rst = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; x_valid = 1'b0; x = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL reset_z got %b want 0", z); end
      checks++; if (match_len !== 3'd0) begin errors++; $display("[TB] FAIL reset_len got %0d want 0", match_len); end
      checks++; if (match_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", match_cnt); end
   endtask

   task automatic run_stream(input string tag, input bit ovl);
      bit bits[7]    = '{1, 0, 1, 1, 0, 1, 1};
      int el_ovl[7]  = '{1, 2, 3, 4, 2, 3, 4};
      int el_novl[7] = '{1, 2, 3, 4, 0, 1, 1};
      int el;
      pattern = 4'b1011; overlap_en = ovl; pmask = '1;
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 0, 1, bits[i]);
         el = ovl ? el_ovl[i] : el_novl[i];
         checks++; if (match_len !== 3'(el)) begin errors++; $display("[TB] FAIL %s_len bit%0d got %0d want %0d", tag, i+1, match_len, el); end
         checks++; if (z !== (el == PW)) begin errors++; $display("[TB] FAIL %s_z bit%0d got %b want %b", tag, i+1, z, (el == PW)); end
      end
      checks++; if (match_cnt !== (ovl ? 2'd2 : 2'd1)) begin errors++; $display("[TB] FAIL %s_cnt got %0d want %0d", tag, match_cnt, ovl ? 2 : 1); end
   endtask

   task automatic test_overlap();
      run_stream("overlap", 1'b1);
   endtask

   task automatic test_non_overlap();
      run_stream("nonoverlap", 1'b0);
   endtask

   task automatic test_gaps();
      bit bits[4] = '{1, 0, 1, 1};
      pattern = 4'b1011; overlap_en = 1'b1;
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, bits[i]);
      for (int g = 0; g < 3; g++) begin
         step(0, 0, 0, 0, 1);
         checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL gap_z cycle%0d got %b want 1", g, z); end
      end
      step(0, 0, 0, 1, 0);
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL gap_drop_z got %b want 0", z); end
      checks++; if (match_len !== 3'd2) begin errors++; $display("[TB] FAIL gap_drop_len got %0d want 2", match_len); end
   endtask

   task automatic test_cfg_mid();
      bit bits[4] = '{0, 1, 1, 0};
      int el[4]   = '{1, 2, 3, 4};
      pattern = 4'b1011; overlap_en = 1'b1;
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1);
      checks++; if (match_len !== 3'd3) begin errors++; $display("[TB] FAIL cfgmid_pre_len got %0d want 3", match_len); end
      pattern = 4'b0110;
      step(0, 1, 0, 1, 1);
      checks++; if (match_len !== 3'd0) begin errors++; $display("[TB] FAIL cfgmid_len got %0d want 0", match_len); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL cfgmid_z got %b want 0", z); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, bits[i]);
         checks++; if (match_len !== 3'(el[i])) begin errors++; $display("[TB] FAIL cfgmid_stream_len bit%0d got %0d want %0d", i+1, match_len, el[i]); end
      end
      checks++; if (match_cnt !== 2'd1) begin errors++; $display("[TB] FAIL cfgmid_cnt got %0d want 1 (cfg_load keeps count)", match_cnt); end
   endtask

   task automatic test_counter();
      pattern = 4'b1011; overlap_en = 1'b1;
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
      for (int m = 2; m <= 5; m++) begin
         step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
         if (m == 2) begin
            checks++; if (match_cnt !== 2'd2) begin errors++; $display("[TB] FAIL cnt_two got %0d want 2", match_cnt); end
         end
      end
      checks++; if (match_cnt !== 2'd3) begin errors++; $display("[TB] FAIL cnt_sat got %0d want 3", match_cnt); end
      step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1);
      step(0, 0, 1, 1, 1);
      checks++; if (match_cnt !== 2'd0) begin errors++; $display("[TB] FAIL cnt_clr_wins got %0d want 0", match_cnt); end
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL cnt_clr_z got %b want 1", z); end
   endtask

   task automatic test_reset_mid();
      pattern = 4'b1011; overlap_en = 1'b0;
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      checks++; if ({z, match_len, match_cnt} !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_outs got z=%b len=%0d cnt=%0d want all 0", z, match_len, match_cnt); end
      // Reset pattern is all zeros with overlap on: five zeros give two matches
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      checks++; if (match_len !== 3'd4) begin errors++; $display("[TB] FAIL rstmid_defaults_len got %0d want 4", match_len); end
      checks++; if (match_cnt !== 2'd2) begin errors++; $display("[TB] FAIL rstmid_defaults_cnt got %0d want 2", match_cnt); end
   endtask

`ifdef SEQ_DET_MASK_EN
   task automatic test_mask();
      pattern = 4'b1001; pmask = 4'b1001; overlap_en = 1'b1;
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL mask_z got %b want 1", z); end
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      checks++; if ({z, match_len, match_cnt} !== 6'd0) begin errors++; $display("[TB] FAIL mask_rst got z=%b len=%0d cnt=%0d want all 0", z, match_len, match_cnt); end
      pmask = '1;
   endtask
`endif

   task automatic test_random();
      bit r, c, clr, xv, xb;
      for (int n = 0; n < 600; n++) begin
         r   = ($urandom_range(0, 59) == 0);
         c   = ($urandom_range(0, 24) == 0);
         clr = ($urandom_range(0, 19) == 0);
         xv  = ($urandom_range(0, 3) != 0);
         xb  = $urandom_range(0, 1);
         if (c) begin
            pattern    = PW'($urandom_range(0, (1 << PW) - 1));
            overlap_en = $urandom_range(0, 1);
            pmask      = PW'($urandom_range(0, (1 << PW) - 1));
         end
         step(r, c, clr, xv, xb);
         checks++; if (match_len !== 3'(m_state)) begin errors++; $display("[TB] FAIL rand_len n=%0d got %0d want %0d", n, match_len, m_state); end
         checks++; if (z !== (m_state == PW)) begin errors++; $display("[TB] FAIL rand_z n=%0d got %b want %b", n, z, (m_state == PW)); end
         checks++; if (match_cnt !== CW'(m_cnt)) begin errors++; $display("[TB] FAIL rand_cnt n=%0d got %0d want %0d", n, match_cnt, m_cnt); end
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_gaps();
      test_cfg_mid();
      test_counter();
      test_reset_mid();
`ifdef SEQ_DET_MASK_EN
      test_mask();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
